// File: rtl/pdh_sample_packer_fifo.sv
// Packs capture samples into 64-bit words and queues them in a first-word-fall-through
// FIFO for the burst-DMA write stage; dropped words are counted and flagged.
module pdh_sample_packer_fifo #(
   parameter int SAMPLE_W = 16,
   parameter int DEPTH    = 512
) (
   input  logic                       aclk,
   input  logic                       rst_ni,
   input  logic                       capture_en_i,
   input  logic [SAMPLE_W-1:0]        sample_i,
   input  logic                       sample_valid_i,
   input  logic                       flush_i,
   output logic [63:0]                data_o,
   output logic                       data_valid_o,
   input  logic                       pop_i,
   output logic [$clog2(DEPTH+1)-1:0] word_count_o,
   output logic                       full_o,
   output logic                       overflow_o,
   output logic                       underflow_o,
   output logic [15:0]                drop_count_o,
   input  logic                       clr_status_i
);

   localparam int LANES = 64 / SAMPLE_W;
   localparam int LW    = $clog2(LANES);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH+1);

   localparam logic [LW-1:0] LAST_LANE = LW'(LANES-1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

   // packer
   logic [LW-1:0] lane_q, lane_d;
   logic [63:0]   pack_q, pack_d;
   logic [63:0]   word_w;
   logic          accept;
   logic          push_req;

   // FIFO
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
   logic [CW-1:0] count_q, count_d;
   logic [63:0]   byp_q, mem_rd_q;
   logic          head_sel_q;
   logic          empty, full;
   logic          do_pop, do_push, drop, under;
   logic          load_byp, mem_rd_en;

   // status
   logic          overflow_q, underflow_q;
   logic [15:0]   drop_cnt_q, drop_cnt_d;

   always_comb begin
      word_w = pack_q;
      word_w[lane_q*SAMPLE_W +: SAMPLE_W] = sample_i;
      accept   = capture_en_i & sample_valid_i;
      push_req = accept & (lane_q == LAST_LANE);

      lane_d = lane_q;
      if (!capture_en_i) begin
         lane_d = '0;
      end else if (sample_valid_i) begin
         lane_d = push_req ? '0 : lane_q + LW'(1);
      end
      pack_d = accept ? word_w : pack_q;
   end

   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == DEPTH_C);
      do_pop  = pop_i & ~empty;
      under   = pop_i & empty;
      do_push = push_req & (~full | do_pop);
      drop    = push_req & ~do_push;
      rd_next = rd_ptr_q + AW'(1);

      // The head comes straight from the packer when the new word is the only one left,
      // since the memory cannot return a word in the same cycle it is written.
      load_byp  = do_push & (empty | (do_pop & (count_q == CW'(1))));
      mem_rd_en = do_pop & (count_q > CW'(1));

      count_d = count_q;
      if (do_push & ~do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop & ~do_push) begin
         count_d = count_q - CW'(1);
      end

      drop_cnt_d = clr_status_i ? 16'h0000 : drop_cnt_q;
      if (drop && drop_cnt_d != 16'hFFFF) begin
         drop_cnt_d = drop_cnt_d + 16'h0001;
      end
   end

   always_ff @(posedge aclk) begin
      if (do_push & ~flush_i) begin
         mem[wr_ptr_q] <= word_w;
      end
      if (mem_rd_en) begin
         mem_rd_q <= mem[rd_next];
      end
   end

   always_ff @(posedge aclk) begin
      if (!rst_ni) begin
         lane_q      <= '0;
         pack_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         byp_q       <= '0;
         head_sel_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else if (flush_i) begin
         lane_q     <= '0;
         pack_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         head_sel_q <= 1'b0;
      end else begin
         lane_q  <= lane_d;
         pack_q  <= pack_d;
         count_q <= count_d;
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_next;
         end
         if (load_byp) begin
            byp_q      <= word_w;
            head_sel_q <= 1'b0;
         end else if (mem_rd_en) begin
            head_sel_q <= 1'b1;
         end
         overflow_q  <= (overflow_q & ~clr_status_i) | drop;
         underflow_q <= (underflow_q & ~clr_status_i) | under;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign data_o       = empty ? 64'h0 : (head_sel_q ? mem_rd_q : byp_q);
   assign data_valid_o = ~empty;
   assign word_count_o = count_q;
   assign full_o       = full;
   assign overflow_o   = overflow_q;
   assign underflow_o  = underflow_q;
   assign drop_count_o = drop_cnt_q;

endmodule
